subtract_square_engine: RTL and testbench

Parametrised SubtractSquare move engine. It runs a full match for N players. Per match it:
- loads an initial heap (pseudo-random or externally supplied);
- accepts one move per turn over a valid/ready handshake and squares the player's input;
- applies the square if it is legal, otherwise applies a forced move (the largest square that fits);
- rotates players and detects game over and the winner.
It sits between the player-input/keypad logic and the display/scoreboard logic.

---
 rtl/subtract_square_engine.sv | 157 +++++++++++++++
 tb/tb_subtract_square_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/subtract_square_engine.sv
// SubtractSquare match engine: loads a heap, squares each accepted root, applies it or the largest fitting square.
// Legal move lands 3 edges after acceptance, forced move 3+k_final; move_ready only in WAIT, extra move_valid ignored.
module subtract_square_engine #(
    parameter int                 STATE_W     = 8,
    parameter int                 INPUT_W     = 4,
    parameter int                 NUM_PLAYERS = 2,
    parameter logic [STATE_W-1:0] LFSR_SEED   = 8'hA5,
    localparam int                PW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               init_sel,
    input  logic [STATE_W-1:0] init_value,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [INPUT_W-1:0] player_input,
    output logic [STATE_W-1:0] game_state,
    output logic [PW-1:0]      current_player,
    output logic [STATE_W-1:0] last_move,
    output logic               forced,
    output logic               move_done,
    output logic               game_over,
    output logic [PW-1:0]      winner,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT, S_EVAL, S_CHECK, S_FORCE, S_APPLY, S_OVER
    } state_t;

    localparam int SW = 2 * INPUT_W;
    localparam int CW = 2 * INPUT_W + 2;

    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h000C;
        endcase
    endfunction

    localparam logic [15:0] TAPS = tap_mask(STATE_W);

    state_t             state, state_nxt;
    logic [STATE_W-1:0] lfsr;
    logic [INPUT_W-1:0] in_reg, k_reg;
    logic [SW-1:0]      sq_reg;
    logic               force_flag;

    logic [INPUT_W:0]   k_inc;
    logic [CW-1:0]      k_inc_sq, gs_ext;
    logic               legal, fits;
    logic [STATE_W-1:0] init_pick, heap_after;

    assign k_inc      = {1'b0, k_reg} + 1'b1;
    assign k_inc_sq   = CW'(k_inc) * CW'(k_inc);
    assign gs_ext     = CW'(game_state);
    assign legal      = (in_reg != '0) && (CW'(sq_reg) <= gs_ext);
    assign fits       = (k_inc_sq <= gs_ext);
    assign init_pick  = init_sel ? init_value : lfsr;
    assign heap_after = game_state - STATE_W'(sq_reg);

    assign move_ready = (state == S_WAIT);
    assign busy       = !(state == S_IDLE || state == S_WAIT || state == S_OVER);

    // Free-running: the value captured at INIT depends on when start arrives.
    always_ff @(posedge clk) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[STATE_W-2:0], ^(lfsr & TAPS[STATE_W-1:0])};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_WAIT;
            S_WAIT:  if (move_valid) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_CHECK;
            S_CHECK: state_nxt = legal ? S_APPLY : S_FORCE;
            S_FORCE: if (!fits) state_nxt = S_APPLY;
            S_APPLY: state_nxt = (heap_after == '0) ? S_OVER : S_WAIT;
            S_OVER:  if (start) state_nxt = S_INIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            game_state     <= '0;
            current_player <= '0;
            last_move      <= '0;
            forced         <= 1'b0;
            move_done      <= 1'b0;
            game_over      <= 1'b0;
            winner         <= '0;
            in_reg         <= '0;
            k_reg          <= '0;
            sq_reg         <= '0;
            force_flag     <= 1'b0;
        end else begin
            move_done <= 1'b0;
            case (state)
                S_INIT: begin
                    game_state     <= (init_pick == '0) ? '1 : init_pick;
                    current_player <= '0;
                    last_move      <= '0;
                    forced         <= 1'b0;
                    game_over      <= 1'b0;
                    winner         <= '0;
                end
                S_WAIT:  if (move_valid) in_reg <= player_input;
                S_EVAL:  sq_reg <= SW'(in_reg) * SW'(in_reg);
                S_CHECK: begin
                    force_flag <= !legal;
                    k_reg      <= INPUT_W'(1);
                end
                S_FORCE: begin
                    if (fits) k_reg  <= k_inc[INPUT_W-1:0];
                    else      sq_reg <= SW'(k_reg) * SW'(k_reg);
                end
                S_APPLY: begin
                    game_state <= heap_after;
                    last_move  <= STATE_W'(sq_reg);
                    forced     <= force_flag;
                    move_done  <= 1'b1;
                    if (heap_after == '0) begin
                        game_over <= 1'b1;
                        winner    <= current_player;
                    end else if (current_player == PW'(NUM_PLAYERS - 1)) begin
                        current_player <= '0;
                    end else begin
                        current_player <= current_player + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subtract_square_engine.sv
// Directed bench: two engines (2 and 3 players) driven by shared stimulus, checked against hand-computed values.
module tb_subtract_square_engine;

    logic       clk = 1'b0;
    logic       reset_n, start, init_sel, move_valid;
    logic [7:0] init_value;
    logic [3:0] player_input;

    logic       move_ready, forced, move_done, game_over, busy;
    logic [7:0] game_state, last_move;
    logic [0:0] current_player, winner;

    logic       move_ready3, forced3, move_done3, game_over3, busy3;
    logic [7:0] game_state3, last_move3;
    logic [1:0] current_player3, winner3;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clk = ~clk;

    subtract_square_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .init_sel(init_sel),
        .init_value(init_value), .move_valid(move_valid), .move_ready(move_ready),
        .player_input(player_input), .game_state(game_state),
        .current_player(current_player), .last_move(last_move), .forced(forced),
        .move_done(move_done), .game_over(game_over), .winner(winner), .busy(busy)
    );

    subtract_square_engine #(.NUM_PLAYERS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .init_sel(init_sel),
        .init_value(init_value), .move_valid(move_valid), .move_ready(move_ready3),
        .player_input(player_input), .game_state(game_state3),
        .current_player(current_player3), .last_move(last_move3), .forced(forced3),
        .move_done(move_done3), .game_over(game_over3), .winner(winner3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic start_match(input logic sel, input logic [7:0] val);
        start = 1'b1; init_sel = sel; init_value = val;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    // Returns the number of edges from acceptance to the move_done pulse (99 on timeout).
    // With hold set, move_valid stays high and player_input changes after acceptance.
    task automatic do_move(input logic [3:0] k, input logic hold, output int n);
        int w = 0;
        while (!move_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        move_valid = 1'b1; player_input = k;
        @(posedge clk); #1;
        if (hold) player_input = 4'd1;
        else      move_valid = 1'b0;
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (move_done) begin
                n = i;
                break;
            end
        end
        move_valid = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".state"}, game_state, 0);
        chk({tag, ".player"}, current_player, 0);
        chk({tag, ".last"}, last_move, 0);
        chk({tag, ".flags"}, {forced, move_done, game_over, busy, move_ready}, 0);
        chk({tag, ".winner"}, winner, 0);
    endtask

    int exp_cp3[4] = '{1, 2, 0, 1};
    int exp_cp2[4] = '{1, 0, 1, 0};

    initial begin
        reset_n = 1'b0; start = 1'b0; init_sel = 1'b0; init_value = '0;
        move_valid = 1'b0; player_input = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset_n = 1'b1;

        start_match(1'b0, 8'd0);
        chk("lfsr_init.nonzero", game_state != 0, 1);
        chk("lfsr_init.ready", move_ready, 1);

        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        start_match(1'b1, 8'd20);
        chk("m1.init_state", game_state, 20);
        chk("m1.init_player", current_player, 0);
        do_move(4'd4, 1'b0, lat);
        chk("m1.latency", lat, 3);
        chk("m1.state", game_state, 4);
        chk("m1.last", last_move, 16);
        chk("m1.forced", forced, 0);
        chk("m1.player", current_player, 1);
        @(posedge clk); #1;
        chk("m1.done_pulse", move_done, 0);
        chk("m1.ready", move_ready, 1);

        start_match(1'b1, 8'd50);
        chk("start_in_wait.state", game_state, 4);
        chk("start_in_wait.ready", move_ready, 1);

        // 9 > 4 forces 2*2; move_valid stays high through EVAL/CHECK/FORCE.
        do_move(4'd3, 1'b1, lat);
        chk("m2.latency", lat, 5);
        chk("m2.state", game_state, 0);
        chk("m2.last", last_move, 4);
        chk("m2.forced", forced, 1);
        chk("m2.over", game_over, 1);
        chk("m2.winner", winner, 1);
        chk("m2.ready", move_ready, 0);

        move_valid = 1'b1; player_input = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        move_valid = 1'b0;
        chk("over_hold.state", game_state, 0);
        chk("over_hold.last", last_move, 4);
        chk("over_hold.flags", {game_over, move_done, busy, move_ready}, 4'b1000);

        start_match(1'b1, 8'd10);
        chk("m3.init_state", game_state, 10);
        chk("m3.init_over", game_over, 0);
        chk("m3.init_player", current_player, 0);
        do_move(4'd0, 1'b0, lat);
        chk("m3.latency", lat, 6);
        chk("m3.state", game_state, 1);
        chk("m3.last", last_move, 9);
        chk("m3.forced", forced, 1);
        do_move(4'd1, 1'b0, lat);
        chk("m3b.latency", lat, 3);
        chk("m3b.state", game_state, 0);
        chk("m3b.forced", forced, 0);
        chk("m3b.over", game_over, 1);
        chk("m3b.winner", winner, 1);

        start_match(1'b1, 8'd0);
        chk("zero_init.state", game_state, 255);

        // Heap 255 with root 0 searches up to k=15; reset lands inside FORCE.
        move_valid = 1'b1; player_input = 4'd0;
        @(posedge clk); #1;
        move_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("force_busy", busy, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs("reset_in_force");
        reset_n = 1'b1;

        start_match(1'b1, 8'd200);
        for (int i = 0; i < 4; i++) begin
            do_move(4'd1, 1'b0, lat);
            chk($sformatf("p3.state%0d", i), game_state3, 199 - i);
            chk($sformatf("p3.player%0d", i), current_player3, exp_cp3[i]);
            chk($sformatf("p2.player%0d", i), current_player, exp_cp2[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
